// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals shared by the arbiter and its requesters.
// master = requesters plus RAM model; slave = the arbiter.
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        merr;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter (data over fetch, with fetch anti-starvation); 2 cycles min per access.
// Requesters are held off via iwait/dwait until RAM reports ACCESS; RAM BUSY/FREE/ERROR stalls the grant.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input logic          CLK,
   input logic          nRST,
   mem_arbiter_if.slave arb_bus
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISERV = 2'd1;
   localparam logic [1:0] DSERV = 2'd2;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic [CW-1:0] r_starve;
   logic [CW-1:0] w_starve_nxt;
   logic          w_dreq;
   logic          w_ack;
   logic          w_i_win;
   logic          w_in_i;
   logic          w_in_d;

   assign w_dreq  = arb_bus.dREN | arb_bus.dWEN;
   assign w_ack   = (arb_bus.ramstate == RS_ACCESS);
   assign w_i_win = arb_bus.iREN & (~w_dreq | (r_starve == CW'(STARVE_LIMIT)));
   assign w_in_i  = (r_state == ISERV);
   assign w_in_d  = (r_state == DSERV);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_i_win)
               w_next = ISERV;
            else if (w_dreq)
               w_next = DSERV;
         end
         ISERV: begin
            if (!arb_bus.iREN || w_ack)
               w_next = IDLE;
         end
         DSERV: begin
            if (!w_dreq || w_ack)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Counts fetch losses in IDLE; any cycle without a fetch request forgets history.
   always_comb begin
      w_starve_nxt = r_starve;
      if (!arb_bus.iREN)
         w_starve_nxt = '0;
      else if (r_state == IDLE) begin
         if (w_i_win)
            w_starve_nxt = '0;
         else if (r_starve != CW'(STARVE_LIMIT))
            w_starve_nxt = r_starve + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_next;
         r_starve <= w_starve_nxt;
      end
   end

   // RAM drivers depend only on state and requester inputs, never on ramstate.
   assign arb_bus.ramREN   = w_in_i | (w_in_d & ~arb_bus.dWEN);
   assign arb_bus.ramWEN   = w_in_d & arb_bus.dWEN;
   assign arb_bus.ramaddr  = w_in_i ? arb_bus.iaddr : (w_in_d ? arb_bus.daddr : 32'd0);
   assign arb_bus.ramstore = w_in_d ? arb_bus.dstore : 32'd0;

   assign arb_bus.iwait = arb_bus.iREN & ~(w_in_i & w_ack);
   assign arb_bus.dwait = w_dreq & ~(w_in_d & w_ack);
   assign arb_bus.iload = w_in_i ? arb_bus.ramload : 32'd0;
   assign arb_bus.dload = w_in_d ? arb_bus.ramload : 32'd0;
   assign arb_bus.merr  = (w_in_i | w_in_d) & (arb_bus.ramstate == RS_ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-level checks plus a completion scoreboard.
module tb_mem_arbiter;

   localparam logic [1:0] FREE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] ERROR  = 2'd3;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic        iw;
      logic        dw;
      logic [31:0] il;
      logic [31:0] dl;
   } txn_t;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   txn_t sb[$];
   txn_t m_obs;
   txn_t m_exp;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(8)) dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .arb_bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk = n_chk + 1;
      assert (obs === want) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, want);
   endtask

   task automatic push(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] store, input logic iw, input logic dw,
                       input logic [31:0] il, input logic [31:0] dl);
      sb.push_back('{ren: ren, wen: wen, addr: addr, store: store, iw: iw, dw: dw, il: il, dl: dl});
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Every RAM completion seen on the bus must match the oldest expected transaction.
   always @(negedge CLK) begin
      if (nRST && (bus.ramREN || bus.ramWEN) && bus.ramstate == ACCESS) begin
         n_chk = n_chk + 1;
         if (sb.size() == 0) begin
            $error("FAIL sb_underflow: observed completion at addr %h expected none", bus.ramaddr);
         end else begin
            m_exp = sb.pop_front();
            m_obs = '{ren: bus.ramREN, wen: bus.ramWEN, addr: bus.ramaddr, store: bus.ramstore,
                      iw: bus.iwait, dw: bus.dwait, il: bus.iload, dl: bus.dload};
            assert (m_obs === m_exp) n_pass = n_pass + 1;
            else $error("FAIL sb_txn: observed %h expected %h", m_obs, m_exp);
         end
      end
   end

   initial begin
      bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
      bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;

      // Reset state, with a data request raised while held in reset
      repeat (2) @(posedge CLK);
      #1 bus.dREN = 1'b1; bus.daddr = 32'h80; bus.iaddr = 32'h40;
      #1;
      chk("rst_ramren", 32'(bus.ramREN), 32'd0);
      chk("rst_ramwen", 32'(bus.ramWEN), 32'd0);
      chk("rst_ramaddr", bus.ramaddr, 32'd0);
      chk("rst_merr", 32'(bus.merr), 32'd0);
      chk("rst_dwait", 32'(bus.dwait), 32'd1);
      chk("rst_iwait", 32'(bus.iwait), 32'd0);
      bus.dREN = 1'b0;
      #1 nRST = 1'b1;

      // Single fetch, ACCESS on its second cycle
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramload = 32'hDEADBEEF;
      #1;
      chk("t1_idle_ren", 32'(bus.ramREN), 32'd0);
      chk("t1_idle_iwait", 32'(bus.iwait), 32'd1);
      tick;
      bus.ramstate = ACCESS;
      push(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0);
      #1;
      chk("t1_ren", 32'(bus.ramREN), 32'd1);
      chk("t1_addr", bus.ramaddr, 32'h40);
      chk("t1_iwait", 32'(bus.iwait), 32'd0);
      chk("t1_iload", bus.iload, 32'hDEADBEEF);
      tick;
      bus.iREN = 1'b0; bus.ramstate = FREE;
      #1;
      chk("t1_idle_after_ren", 32'(bus.ramREN), 32'd0);
      chk("t1_idle_after_addr", bus.ramaddr, 32'd0);
      chk("t1_idle_after_iload", bus.iload, 32'd0);

      // Simultaneous fetch and data read: data first, fetch after one IDLE
      bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h80;
      bus.ramload = 32'h11111111;
      tick;
      chk("t2_dserv_addr", bus.ramaddr, 32'h80);
      chk("t2_dserv_ren", 32'(bus.ramREN), 32'd1);
      chk("t2_dserv_iwait", 32'(bus.iwait), 32'd1);
      chk("t2_dserv_dwait", 32'(bus.dwait), 32'd1);
      bus.ramstate = ACCESS;
      push(1'b1, 1'b0, 32'h80, 32'd0, 1'b1, 1'b0, 32'd0, 32'h11111111);
      #1;
      chk("t2_acc_dwait", 32'(bus.dwait), 32'd0);
      chk("t2_acc_iwait", 32'(bus.iwait), 32'd1);
      tick;
      bus.dREN = 1'b0; bus.ramstate = FREE;
      #1;
      chk("t2_gap_ren", 32'(bus.ramREN), 32'd0);
      chk("t2_gap_iwait", 32'(bus.iwait), 32'd1);
      tick;
      chk("t2_iserv_addr", bus.ramaddr, 32'h44);
      chk("t2_iserv_iwait", 32'(bus.iwait), 32'd1);
      bus.ramload = 32'h22222222; bus.ramstate = ACCESS;
      push(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 1'b0, 32'h22222222, 32'd0);
      tick;
      bus.iREN = 1'b0; bus.ramstate = FREE;

      // Starvation: continuous data writes against a pending fetch
      bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dREN = 1'b1; bus.dWEN = 1'b1;
      bus.daddr = 32'h90; bus.dstore = 32'hA5A5A5A5; bus.ramload = 32'd0;
      for (int k = 0; k < 8; k++) begin
         tick;
         chk("t3_loss_wen", 32'(bus.ramWEN), 32'd1);
         chk("t3_loss_ren", 32'(bus.ramREN), 32'd0);
         bus.ramstate = ACCESS;
         push(1'b0, 1'b1, 32'h90, 32'hA5A5A5A5, 1'b1, 1'b0, 32'd0, 32'd0);
         tick;
         bus.ramstate = FREE;
      end
      tick;
      chk("t3_grant_ren", 32'(bus.ramREN), 32'd1);
      chk("t3_grant_wen", 32'(bus.ramWEN), 32'd0);
      chk("t3_grant_addr", bus.ramaddr, 32'h48);
      chk("t3_grant_dwait", 32'(bus.dwait), 32'd1);
      bus.ramload = 32'h33333333; bus.ramstate = ACCESS;
      push(1'b1, 1'b0, 32'h48, 32'd0, 1'b0, 1'b1, 32'h33333333, 32'd0);
      tick;
      bus.ramstate = FREE; bus.ramload = 32'd0;
      tick;
      chk("t3_cnt_cleared_wen", 32'(bus.ramWEN), 32'd1);
      bus.ramstate = ACCESS;
      push(1'b0, 1'b1, 32'h90, 32'hA5A5A5A5, 1'b1, 1'b0, 32'd0, 32'd0);
      tick;
      bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;

      // Data write with two ERROR cycles before ACCESS
      bus.dWEN = 1'b1; bus.daddr = 32'hA0; bus.dstore = 32'h12345678;
      tick;
      bus.ramstate = ERROR;
      #1;
      chk("t4_merr1", 32'(bus.merr), 32'd1);
      chk("t4_wen1", 32'(bus.ramWEN), 32'd1);
      chk("t4_dwait1", 32'(bus.dwait), 32'd1);
      tick;
      chk("t4_merr2", 32'(bus.merr), 32'd1);
      chk("t4_wen2", 32'(bus.ramWEN), 32'd1);
      chk("t4_addr2", bus.ramaddr, 32'hA0);
      chk("t4_dwait2", 32'(bus.dwait), 32'd1);
      bus.ramstate = ACCESS;
      push(1'b0, 1'b1, 32'hA0, 32'h12345678, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("t4_merr_acc", 32'(bus.merr), 32'd0);
      chk("t4_dwait_acc", 32'(bus.dwait), 32'd0);
      tick;
      bus.dWEN = 1'b0; bus.ramstate = FREE;
      #1;
      chk("t4_idle_merr", 32'(bus.merr), 32'd0);
      chk("t4_idle_wen", 32'(bus.ramWEN), 32'd0);

      // Reset pulse during a BUSY data read
      bus.dREN = 1'b1; bus.daddr = 32'hB0; bus.dstore = 32'd0;
      tick;
      bus.ramstate = BUSY;
      #1;
      chk("t5_busy_ren", 32'(bus.ramREN), 32'd1);
      chk("t5_busy_addr", bus.ramaddr, 32'hB0);
      #1 nRST = 1'b0;
      #1;
      chk("t5_rst_ren", 32'(bus.ramREN), 32'd0);
      chk("t5_rst_addr", bus.ramaddr, 32'd0);
      chk("t5_rst_dwait", 32'(bus.dwait), 32'd1);
      bus.ramstate = ERROR;
      #1;
      chk("t5_rst_merr", 32'(bus.merr), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      bus.ramstate = BUSY;
      nRST = 1'b1;
      tick;
      chk("t5_rearb_ren", 32'(bus.ramREN), 32'd1);
      chk("t5_rearb_addr", bus.ramaddr, 32'hB0);
      bus.ramload = 32'h55555555; bus.ramstate = ACCESS;
      push(1'b1, 1'b0, 32'hB0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h55555555);
      tick;
      bus.dREN = 1'b0; bus.ramstate = FREE;

      // Fetch dropped while RAM is BUSY
      bus.iREN = 1'b1; bus.iaddr = 32'hC0;
      tick;
      bus.ramstate = BUSY;
      #1;
      chk("t6_ren", 32'(bus.ramREN), 32'd1);
      chk("t6_iwait", 32'(bus.iwait), 32'd1);
      tick;
      chk("t6_hold_ren", 32'(bus.ramREN), 32'd1);
      chk("t6_hold_addr", bus.ramaddr, 32'hC0);
      bus.iREN = 1'b0;
      #1;
      chk("t6_drop_iwait", 32'(bus.iwait), 32'd0);
      chk("t6_drop_ren", 32'(bus.ramREN), 32'd1);
      tick;
      chk("t6_idle_ren", 32'(bus.ramREN), 32'd0);
      chk("t6_idle_iwait", 32'(bus.iwait), 32'd0);
      tick;
      chk("t6_idle2_ren", 32'(bus.ramREN), 32'd0);
      bus.ramstate = FREE;

      tick;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      tick;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
